// File: rtl/sync_serial_rx.sv
// sync_serial_rx
//   Receive end of the bit-serial shift link. Collects strobed serial bits
//   into WIDTH-bit words and presents each word on a valid/ready port with
//   one word of output buffering. Words that complete while the output is
//   still held are dropped and counted.
//
// Parameters
//   WIDTH      data bits per frame (2..32)
//   MSB_FIRST  1: first serial bit lands in m_data[WIDTH-1]
//              0: first serial bit lands in m_data[0]
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   s_bit_en   bit strobe; s_start/s_data are sampled only when high
//   s_start    strobed bit is the first bit of a frame
//   s_data     serial data bit
//   m_data     received word
//   m_valid    m_data holds an unconsumed word
//   m_ready    consumer accepts m_data this cycle
//   busy       frame in progress
//   overrun    one-cycle pulse: completed word dropped
//   frame_err  one-cycle pulse: partial frame aborted by a new s_start
//   drop_cnt   dropped-word count, saturating at 255
module sync_serial_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_bit_en,
  input  logic             s_start,
  input  logic             s_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic [7:0]       drop_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             word_done;
  logic             frame_err_n;

  // Place one new serial bit according to the configured bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic             b);
    if (MSB_FIRST) return {v[WIDTH-2:0], b};
    else           return {b, v[WIDTH-1:1]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Frame assembly: state, bit count and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    word_done   = 1'b0;
    frame_err_n = 1'b0;
    if (s_bit_en) begin
      unique case (state)
        IDLE: begin
          if (s_start) begin
            shreg_n = shift_in('0, s_data);
            cnt_n   = CNT_ONE;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (s_start) begin
            // Restart: the partial frame is discarded, new bit 1 captured.
            frame_err_n = 1'b1;
            shreg_n     = shift_in('0, s_data);
            cnt_n       = CNT_ONE;
          end else begin
            shreg_n = shift_in(shreg, s_data);
            if (cnt == CNT_LAST) begin
              word_done = 1'b1;
              cnt_n     = '0;
              state_n   = IDLE;
            end else begin
              cnt_n = cnt + CNT_ONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);

  // Output buffer, drop accounting and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= frame_err_n;
      if (word_done) begin
        // A held word being consumed this cycle frees the buffer for the new one.
        if (!m_valid || m_ready) begin
          m_data  <= shreg_n;
          m_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
          drop_cnt <= sat_inc(drop_cnt);
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_serial_rx.sv
// tb_sync_serial_rx
//   Directed bench for sync_serial_rx. Two instances share the stimulus:
//   dut0 receives MSB first, dut1 receives LSB first. Inputs change on the
//   falling edge and outputs are sampled on the falling edge.
module tb_sync_serial_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_bit_en = 1'b0;
  logic       s_start = 1'b0;
  logic       s_data = 1'b0;
  logic       m_ready = 1'b0;

  logic [7:0] m_data0, m_data1;
  logic       m_valid0, m_valid1;
  logic       busy0, busy1;
  logic       overrun0, overrun1;
  logic       frame_err0, frame_err1;
  logic [7:0] drop_cnt0, drop_cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  always #5 clk = ~clk;

  sync_serial_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .s_bit_en(s_bit_en), .s_start(s_start),
    .s_data(s_data), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
    .busy(busy0), .overrun(overrun0), .frame_err(frame_err0),
    .drop_cnt(drop_cnt0)
  );

  sync_serial_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .s_bit_en(s_bit_en), .s_start(s_start),
    .s_data(s_data), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
    .busy(busy1), .overrun(overrun1), .frame_err(frame_err1),
    .drop_cnt(drop_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and accumulate dut0 status activity.
  task automatic tick();
    @(negedge clk);
    busy_cyc += int'(busy0);
    ferr_cnt += int'(frame_err0);
    ovr_cnt  += int'(overrun0);
  endtask

  task automatic clr_stats();
    busy_cyc = 0;
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic strobe(input logic st, input logic d, input int gap);
    repeat (gap) tick();
    s_bit_en = 1'b1;
    s_start  = st;
    s_data   = d;
    tick();
    s_bit_en = 1'b0;
    s_start  = 1'b0;
    s_data   = 1'b0;
  endtask

  // Send the first nbits of w (MSB-first order when msb=1), s_start on bit 1.
  task automatic send_bits(input logic [7:0] w, input bit msb,
                           input int nbits, input int gap);
    for (int i = 0; i < nbits; i++)
      strobe(i == 0, msb ? w[7-i] : w[i], gap);
  endtask

  task automatic send_word(input logic [7:0] w, input bit msb, input int gap);
    send_bits(w, msb, 8, gap);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_m_data",    m_data0,    8'h00);
    check("rst_m_valid",   m_valid0,   1'b0);
    check("rst_busy",      busy0,      1'b0);
    check("rst_overrun",   overrun0,   1'b0);
    check("rst_frame_err", frame_err0, 1'b0);
    check("rst_drop_cnt",  drop_cnt0,  8'h00);
    reset = 1'b1;
    tick();

    // MSB first, consumer always ready
    m_ready = 1'b1;
    clr_stats();
    send_word(8'hA5, 1'b1, 0);
    check("a5_busy_cycles", busy_cyc, 7);
    check("a5_valid",       m_valid0, 1'b1);
    check("a5_data",        m_data0,  8'hA5);
    check("a5_data_lsbf",   m_data1,  8'hA5);
    tick();
    check("a5_valid_drop",  m_valid0, 1'b0);
    check("a5_data_hold",   m_data0,  8'hA5);

    // LSB first: bits 0,0,0,0,1,1,1,1
    send_word(8'hF0, 1'b0, 0);
    check("f0_lsbf_data",   m_data1,  8'hF0);
    check("f0_lsbf_valid",  m_valid1, 1'b1);
    check("f0_msbf_data",   m_data0,  8'h0F);
    tick();

    // Held word, second word dropped
    m_ready = 1'b0;
    clr_stats();
    send_word(8'h3C, 1'b1, 0);
    check("hold_valid",     m_valid0, 1'b1);
    check("hold_data",      m_data0,  8'h3C);
    send_word(8'h81, 1'b1, 0);
    check("ovr_pulse",      overrun0, 1'b1);
    check("ovr_drop_cnt",   drop_cnt0, 8'd1);
    check("ovr_data_kept",  m_data0,  8'h3C);
    tick();
    check("ovr_pulse_end",  overrun0, 1'b0);
    check("ovr_once",       ovr_cnt,  1);
    m_ready = 1'b1;
    tick();
    check("xfer_valid",     m_valid0, 1'b0);
    check("xfer_data",      m_data0,  8'h3C);

    // Aborted partial frame, full strobe rate
    clr_stats();
    send_bits(8'hE0, 1'b1, 3, 0);
    send_word(8'h5A, 1'b1, 0);
    check("ferr_once",      ferr_cnt, 1);
    check("ferr_data",      m_data0,  8'h5A);
    check("ferr_valid",     m_valid0, 1'b1);
    send_word(8'h0F, 1'b1, 0);
    tick();
    check("pre_gap_data",   m_data0,  8'h0F);

    // Same abort with 5-cycle strobe gaps
    clr_stats();
    send_bits(8'hE0, 1'b1, 3, 5);
    send_word(8'h5A, 1'b1, 5);
    check("gap_ferr_once",  ferr_cnt, 1);
    check("gap_data",       m_data0,  8'h5A);
    check("gap_valid",      m_valid0, 1'b1);
    tick();

    // Completion coinciding with consumption of a held word
    m_ready = 1'b0;
    send_word(8'h11, 1'b1, 0);
    check("held11_data",    m_data0,  8'h11);
    clr_stats();
    send_bits(8'h22, 1'b1, 7, 0);
    m_ready = 1'b1;
    strobe(1'b0, 1'b0, 0);
    check("coin_no_ovr",    ovr_cnt,  0);
    check("coin_valid",     m_valid0, 1'b1);
    check("coin_data",      m_data0,  8'h22);

    // Saturation of the drop counter
    m_ready = 1'b0;
    clr_stats();
    repeat (300) send_word(8'h99, 1'b1, 0);
    check("sat_ovr_pulses", ovr_cnt,  300);
    check("sat_drop_cnt",   drop_cnt0, 8'd255);
    check("sat_data_kept",  m_data0,  8'h22);
    check("sat_valid",      m_valid0, 1'b1);

    // Reset mid-frame with a held word
    send_bits(8'hFF, 1'b1, 5, 0);
    check("mid_busy",       busy0,    1'b1);
    reset = 1'b0;
    #1;
    check("arst_m_data",    m_data0,   8'h00);
    check("arst_m_valid",   m_valid0,  1'b0);
    check("arst_busy",      busy0,     1'b0);
    check("arst_drop_cnt",  drop_cnt0, 8'h00);
    check("arst_overrun",   overrun0,  1'b0);
    check("arst_frame_err", frame_err0, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    m_ready = 1'b1;
    clr_stats();
    send_word(8'hC3, 1'b1, 0);
    check("post_rst_data",  m_data0,  8'hC3);
    check("post_rst_valid", m_valid0, 1'b1);
    check("post_rst_ferr",  ferr_cnt, 0);
    check("post_rst_ovr",   ovr_cnt,  0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
